// File: rtl/imm_ext_pipe_if.sv
// Handshake bundle for the ID->EX immediate extender.
// Decoder-side input, EX-side output and flush.
interface imm_ext_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [2:0]       in_mode;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_err;

  modport master (
    output in_valid, in_imm, in_mode,
    output flush, out_ready,
    input  in_ready, out_valid,
    input  out_data, out_err
  );

  modport slave (
    input  in_valid, in_imm, in_mode,
    input  flush, out_ready,
    output in_ready, out_valid,
    output out_data, out_err
  );
endinterface

// File: rtl/imm_ext_pipe.sv
// Registered immediate/shamt extender with a
// 2-entry elastic buffer (output reg + skid reg).
module imm_ext_pipe #(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  imm_ext_pipe_if.slave  bus
);
  localparam int PAD = OUT_W - IN_W;

  logic [OUT_W-1:0] w_data;
  logic             w_err;
  logic             w_sign;
  logic             w_in_fire;
  logic             w_out_free;

  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_data;
  logic             r_out_err;
  logic             r_skid_valid;
  logic [OUT_W-1:0] r_skid_data;
  logic             r_skid_err;

  assign w_sign = bus.in_imm[IN_W-1];

  always_comb begin
    w_data = '0;
    w_err  = 1'b0;
    unique case (1'b1)
      (bus.in_mode == 3'b000):
        w_data = {{PAD{1'b0}}, bus.in_imm};
      (bus.in_mode == 3'b001):
        w_data = {{PAD{w_sign}}, bus.in_imm};
      (bus.in_mode == 3'b010):
        w_data = {bus.in_imm, {PAD{1'b0}}};
      (bus.in_mode == 3'b011):
        w_data = {{(PAD-2){w_sign}},
                  bus.in_imm, 2'b00};
      (bus.in_mode == 3'b100):
        w_data = {{(OUT_W-SHAMT_W){1'b0}},
                  bus.in_imm[SHAMT_W-1:0]};
      default:
        w_err  = 1'b1;
    endcase
  end

  // Ready depends only on registered state; no out_ready path.
  assign bus.in_ready = !r_skid_valid && !rst;
  assign w_in_fire    = bus.in_valid && bus.in_ready;
  assign w_out_free   = !r_out_valid || bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_err    <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_err   <= 1'b0;
    end else if (bus.flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      // Skid valid implies no input fire, so skid just drains.
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_out_err    <= r_skid_err;
        r_skid_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= w_data;
        r_out_err    <= w_err;
      end else begin
        r_out_valid  <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= w_data;
      r_skid_err   <= w_err;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_err   = r_out_err;
endmodule
